// File: rtl/store_rmw_seq.sv
// store_rmw_seq: read-modify-write sequencer turning SB/SH/SW into whole-word memory writes.
// Define STORE_RMW_FWD_EN to merge sub-word stores into the last written word without a read.
module store_rmw_seq #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        busy,
  output logic        done,
  output logic        err_align,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, WAIT = 3'd2, WRITE = 3'd3, DONE = 3'd4;
  logic [2:0] state, cnt;
  logic [31:0] addr_q, wdata_q, word_q, fwd_src;
  logic [1:0] size_q;
  logic err_q, bad, hit;
  function automatic logic [31:0] merge(input logic [31:0] rd, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] r;
    r = rd;
    if (sz == 2'd0) r[{off, 3'b000} +: 8] = wd[7:0];
    else if (sz == 2'd1) r[{off[1], 4'b0000} +: 16] = wd[15:0];
    else r = wd;
    return r;
  endfunction
  assign bad = (req_size == 2'd3) || (req_size == 2'd1 && req_addr[0]) ||
               (req_size == 2'd2 && req_addr[1:0] != 2'b00);
`ifdef STORE_RMW_FWD_EN
  logic [29:0] fwd_addr;
  logic        fwd_v;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      fwd_v   <= 1'b0;
      fwd_addr <= '0;
      fwd_src <= '0;
    end else if (state == WRITE) begin
      fwd_v   <= 1'b1;
      fwd_addr <= addr_q[31:2];
      fwd_src <= word_q;
    end
  assign hit = fwd_v && fwd_addr == req_addr[31:2] && req_size != 2'd2;
`else
  assign hit = 1'b0;
  assign fwd_src = '0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          size_q  <= req_size;
          err_q   <= bad;
          cnt     <= '0;
          // word stores and forwarding hits have their final word ready at accept
          word_q  <= merge(fwd_src, req_wdata, req_size, req_addr[1:0]);
          state   <= bad ? DONE : (req_size == 2'd2 || hit) ? WRITE : READ;
        end
        READ: state <= WAIT;
        WAIT: if (cnt == 3'(MEM_LAT - 1)) begin
          word_q <= merge(mem_rdata, wdata_q, size_q, addr_q[1:0]);
          state  <= WRITE;
        end else cnt <= cnt + 3'd1;
        WRITE: state <= DONE;
        DONE: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign mem_rd    = state == READ;
  assign mem_wr    = state == WRITE;
  assign done      = state == DONE;
  assign err_align = done && err_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = word_q;
endmodule

// File: tb/tb_store_rmw_seq.sv
// tb_store_rmw_seq: directed stores checked cycle by cycle against a transaction-level model.
module tb_store_rmw_seq;
  localparam int MEM_LAT = 1;
  logic clk = 0, reset_n = 0, req_valid = 0;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;
  logic [1:0] req_size = 0;
  logic req_ready, busy, done, err_align, mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;

  store_rmw_seq #(.MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .busy(busy),
    .done(done), .err_align(err_align), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic idle, rd, wr, dn, err, ca;
    logic [31:0] addr, data;
  } exp_t;
  exp_t exp_q[$];
  int total = 0, bad = 0, cyc = 0, due = -1, acc = 0, wr_at = -1, done_at = -1, rd_n = 0, wr_n = 0;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic [31:0] rword = 0, last_wr = 0, last_wa = 0;
  logic fv = 0;
  logic [29:0] fa = 0;
  bit en = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  function automatic exp_t mk(input logic idle, rd, wr, dn, err, ca, input logic [31:0] addr, data);
    exp_t e;
    e.idle = idle; e.rd = rd; e.wr = wr; e.dn = dn; e.err = err; e.ca = ca;
    e.addr = addr; e.data = data;
    return e;
  endfunction

  // lane-mask formulation of the store merge
  function automatic logic [31:0] exp_merge(input logic [31:0] old, wd, input logic [1:0] s, input logic [31:0] a);
    logic [31:0] mask, dat;
    mask = s == 2'd0 ? 32'hFF << (8 * a[1:0]) : s == 2'd1 ? (a[1] ? 32'hFFFF0000 : 32'h0000FFFF) : 32'hFFFFFFFF;
    dat  = s == 2'd0 ? {4{wd[7:0]}} : s == 2'd1 ? {2{wd[15:0]}} : wd;
    return (old & ~mask) | (dat & mask);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // memory: read data valid MEM_LAT cycles after the mem_rd cycle, garbage otherwise
  always @(negedge clk)
    if (reset_n) begin
      if (mem_rd) begin
        due = cyc + MEM_LAT;
        rword = mem[mem_addr[11:2]];
      end
      mem_rdata = (cyc == due) ? rword : 32'hBAD0BAD0;
      if (mem_wr) begin
        mem[mem_addr[11:2]] = mem_wdata;
        wr_n++;
      end
    end

  always @(negedge clk)
    if (reset_n && en) begin
      exp_t e;
      e = exp_q.size() > 0 ? exp_q.pop_front() : mk(1, 0, 0, 0, 0, 0, 0, 0);
      chk("flags{ready,busy,rd,wr,done,err}", 32'({req_ready, busy, mem_rd, mem_wr, done, err_align}),
          32'({e.idle, !e.idle, e.rd, e.wr, e.dn, e.err}));
      if (e.ca) chk("mem_addr", mem_addr, e.addr);
      if (e.wr) chk("mem_wdata", mem_wdata, e.data);
      if (mem_wr) begin
        last_wr = mem_wdata;
        last_wa = mem_addr;
        wr_at = cyc - acc;
      end
      if (done) done_at = cyc - acc;
      if (mem_rd) rd_n++;
    end

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    logic rej, hit;
    logic [31:0] wad, nw;
    rej = s == 2'd3 || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00);
`ifdef STORE_RMW_FWD_EN
    hit = fv && fa == a[31:2] && s != 2'd2;
`else
    hit = 1'b0;
`endif
    wad = {a[31:2], 2'b00};
    nw = exp_merge(ref_mem[a[11:2]], d, s, a);
    wr_at = -1;
    done_at = -1;
    req_valid = 1; req_addr = a; req_wdata = d; req_size = s;
    acc = cyc;
    exp_q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
    if (rej) exp_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0));
    else begin
      if (s != 2'd2 && !hit) begin
        exp_q.push_back(mk(0, 1, 0, 0, 0, 1, wad, 0));
        repeat (MEM_LAT) exp_q.push_back(mk(0, 0, 0, 0, 0, 1, wad, 0));
      end
      exp_q.push_back(mk(0, 0, 1, 0, 0, 1, wad, nw));
      exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
      ref_mem[a[11:2]] = nw;
      fv = 1;
      fa = a[31:2];
    end
    @(posedge clk); #1;
    req_valid = 0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_size = 2'd2;
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL timeout waiting for store %h to complete", a);
      exp_q.delete();
    end
  endtask

  typedef struct { logic [31:0] a, d; logic [1:0] s; } vec_t;
  vec_t vecs[8] = '{
    '{32'h103, 32'h0000_0077, 2'd0}, '{32'h100, 32'hFFFF_FF5A, 2'd0},
    '{32'h200, 32'h0000_1234, 2'd1}, '{32'h10C, 32'hCAFE_F00D, 2'd2},
    '{32'h010, 32'h0000_0001, 2'd3}, '{32'h302, 32'h1111_1111, 2'd2},
    '{32'h203, 32'h0000_4321, 2'd1}, '{32'h0FD, 32'h0000_00E1, 2'd0}
  };

  initial begin
    int r, w;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E37_79B9;
    mem[32'h40] = 32'h1122_3344;
    mem[32'h80] = 32'hAAAA_5555;
    for (int i = 0; i < 1024; i++) ref_mem[i] = mem[i];
    #12;
    chk("reset flags{ready,busy,done,err,rd,wr}", 32'({req_ready, busy, done, err_align, mem_rd, mem_wr}), 32'b100000);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_wdata", mem_wdata, 0);
    @(posedge clk); #1;
    reset_n = 1;
    en = 1;
    @(posedge clk); #1;

    store(32'h102, 32'h0000_00AB, 2'd0);
    chk("sb data", last_wr, 32'h11AB_3344);
    chk("sb addr", last_wa, 32'h100);
    chk("sb write cycle", wr_at, 2 + MEM_LAT);
    chk("sb done cycle", done_at, 3 + MEM_LAT);

    store(32'h202, 32'h0000_BEEF, 2'd1);
    chk("sh data", last_wr, 32'hBEEF_5555);
    chk("sh write cycle", wr_at, 2 + MEM_LAT);

    r = rd_n;
    store(32'h300, 32'hDEAD_BEEF, 2'd2);
    chk("sw data", last_wr, 32'hDEAD_BEEF);
    chk("sw write cycle", wr_at, 1);
    chk("sw done cycle", done_at, 2);
    chk("sw no read", rd_n, r);

    w = wr_n;
    store(32'h001, 32'h0000_1234, 2'd1);
    chk("misaligned sh done cycle", done_at, 1);
    store(32'h010, 32'h0000_0055, 2'd3);
    chk("illegal size done cycle", done_at, 1);
    chk("rejects no read", rd_n, r);
    chk("rejects no write", wr_n, w);

    foreach (vecs[i]) store(vecs[i].a, vecs[i].d, vecs[i].s);

    en = 0;
    req_valid = 1; req_addr = 32'h106; req_wdata = 32'h99; req_size = 2'd0;
    @(posedge clk); #1;
    req_valid = 0;
    chk("rst-test read{rd,busy}", 32'({mem_rd, busy}), 2'b11);
    @(posedge clk); #1;
    chk("rst-test wait{rd,wr,busy}", 32'({mem_rd, mem_wr, busy}), 3'b001);
    w = wr_n;
    reset_n = 0;
    #1;
    chk("async reset{ready,busy,done,rd,wr}", 32'({req_ready, busy, done, mem_rd, mem_wr}), 5'b10000);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
    fv = 0;
    exp_q.delete();
    en = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("no write after reset", wr_n, w);
    chk("ready after reset", 32'(req_ready), 1);

    store(32'h400, 32'h1234_5678, 2'd2);
    r = rd_n;
    store(32'h401, 32'h0000_00CC, 2'd0);
    chk("fwd data", last_wr, 32'h1234_CC78);
`ifdef STORE_RMW_FWD_EN
    chk("fwd no read", rd_n, r);
    chk("fwd done cycle", done_at, 2);
`else
    chk("no-fwd read", rd_n, r + 1);
    chk("no-fwd done cycle", done_at, 3 + MEM_LAT);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
